// File: rtl/mc_stage_ctrl.sv
// mc_stage_ctrl: IF/ID/EXE/MEM/WB sequencer for the multi-cycle core.
// Ports: clk, resetn (sync, active-low); dec_is_load/dec_is_store/
//   dec_gr_we from the decoder; stall_req holds fetch; cnt_clr clears
//   the counters. Outputs: state, SRAM strobes (inst_req, ir_we,
//   data_req, data_we, mdr_we), commit strobes (rf_we, pc_we, retire)
//   and cycle_cnt / instret_cnt performance counters.
module mc_stage_ctrl #(
   parameter int IRAM_LAT = 1,
   parameter int DRAM_LAT = 1,
   parameter int SKIP_MEM = 1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             dec_is_load,
   input  logic             dec_is_store,
   input  logic             dec_gr_we,
   input  logic             stall_req,
   input  logic             cnt_clr,
   output logic [2:0]       state,
   output logic             inst_req,
   output logic             ir_we,
   output logic             data_req,
   output logic             data_we,
   output logic             mdr_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic             retire,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [3:0] IWAIT = 4'(IRAM_LAT - 1);
   localparam logic [3:0] DWAIT = 4'(DRAM_LAT - 1);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t     st;
   logic [3:0] wcnt;
   // run is low for the cycle after any reset edge, so no strobe can
   // fire while reset is applied; it also holds the FSM in IF then.
   logic       run;

   logic in_if, in_mem, in_wb, wdone, go_mem;

   assign in_if  = run && (st == S_IF);
   assign in_mem = run && (st == S_MEM);
   assign in_wb  = run && (st == S_WB);
   assign wdone  = (wcnt == 4'd0);
   // load wins when both decode bits are (illegally) set
   assign go_mem = dec_is_load || dec_is_store || (SKIP_MEM == 0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         st          <= S_IF;
         wcnt        <= IWAIT;
         run         <= 1'b0;
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         run <= 1'b1;
         if (run) begin
            unique case (st)
               S_IF: begin
                  if (stall_req)
                     wcnt <= IWAIT;
                  else if (wdone)
                     st <= S_ID;
                  else
                     wcnt <= wcnt - 4'd1;
               end
               S_ID: st <= S_EXE;
               S_EXE: begin
                  if (go_mem) begin
                     st   <= S_MEM;
                     wcnt <= DWAIT;
                  end else begin
                     st <= S_WB;
                  end
               end
               S_MEM: begin
                  if (dec_is_load && !wdone)
                     wcnt <= wcnt - 4'd1;
                  else
                     st <= S_WB;
               end
               S_WB: begin
                  st   <= S_IF;
                  wcnt <= IWAIT;
               end
               default: begin
                  st   <= S_IF;
                  wcnt <= IWAIT;
               end
            endcase
         end
         if (cnt_clr) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
         end else begin
            cycle_cnt <= cycle_cnt + ONE;
            if (retire)
               instret_cnt <= instret_cnt + ONE;
         end
      end
   end

   assign state    = st;
   assign inst_req = in_if && !stall_req;
   assign ir_we    = inst_req && wdone;
   assign data_req = in_mem && (dec_is_load || dec_is_store);
   assign data_we  = in_mem && !dec_is_load && dec_is_store;
   assign mdr_we   = in_mem && dec_is_load && wdone;
   assign rf_we    = in_wb && dec_gr_we;
   assign pc_we    = in_wb;
   assign retire   = in_wb;

endmodule
